// File: rtl/distb_fir_pkg.sv
// Shared constants, state encoding and helpers for the distributed-arithmetic
// FIR sequencer. Optional feature macro: DISTB_FIR_SCALE_EN (output rescaled
// by the coefficient sum with rounding).
package distb_fir_pkg;

    localparam int TAPS        = 4;
    localparam int DATA_WIDTH  = 8;
    localparam int COEF_WIDTH  = 12;
    localparam int ACC_WIDTH   = COEF_WIDTH + DATA_WIDTH;
    localparam int SCALE_SHIFT = 10;
    localparam int BIT_CNT_W   = $clog2(DATA_WIDTH);

    // Half of the scale divisor, added before the arithmetic shift to round.
    localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(2 ** (SCALE_SHIFT - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // ROM words are unsigned partial sums: widen with zeros, then treat as signed.
    function automatic logic signed [ACC_WIDTH-1:0] coef_extend(input logic [COEF_WIDTH-1:0] word);
        return $signed({{(ACC_WIDTH - COEF_WIDTH){1'b0}}, word});
    endfunction

endpackage

// File: rtl/distb_table.sv
// Coefficient-sum ROM for the 4-tap distributed-arithmetic FIR.
// Address bit i selects coefficient c_i (c0=41, c1=132, c2=341, c3=510);
// each word is the sum of the selected coefficients. The full sum is 1024.
module distb_table
    import distb_fir_pkg::*;
(
    input  logic [TAPS-1:0]       addr,
    output logic [COEF_WIDTH-1:0] data
);

    // Combinational lookup of the partial coefficient sum.
    always_comb begin
        data = 12'd0;
        case (addr)
            4'd0:    data = 12'd0;
            4'd1:    data = 12'd41;
            4'd2:    data = 12'd132;
            4'd3:    data = 12'd173;
            4'd4:    data = 12'd341;
            4'd5:    data = 12'd382;
            4'd6:    data = 12'd473;
            4'd7:    data = 12'd514;
            4'd8:    data = 12'd510;
            4'd9:    data = 12'd551;
            4'd10:   data = 12'd642;
            4'd11:   data = 12'd683;
            4'd12:   data = 12'd851;
            4'd13:   data = 12'd892;
            4'd14:   data = 12'd983;
            4'd15:   data = 12'd1024;
            default: data = 12'd0;
        endcase
    end

endmodule

// File: rtl/distb_fir_ctrl.sv
// Bit-serial sequencer for the 4-tap distributed-arithmetic FIR.
// Accepts one sample per handshake, shifts the delay line, then walks the
// sample bits LSB first, shift-accumulating ROM partial sums; the sign bit
// weight is subtracted. Optional macro DISTB_FIR_SCALE_EN rounds and divides
// the result by 1024 in the CALC->DONE transition.
module distb_fir_ctrl
    import distb_fir_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  out_data,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] CNT_ONE  = BIT_CNT_W'(1);

    state_t                       state_r;
    logic [DATA_WIDTH-1:0]        tap0_r;
    logic [DATA_WIDTH-1:0]        tap1_r;
    logic [DATA_WIDTH-1:0]        tap2_r;
    logic [DATA_WIDTH-1:0]        tap3_r;
    logic signed [ACC_WIDTH-1:0]  acc_r;
    logic [BIT_CNT_W-1:0]         bit_cnt_r;
    logic [ACC_WIDTH-1:0]         out_data_r;
    logic                         out_valid_r;
    logic                         in_ready_r;
    logic                         busy_r;

    logic [TAPS-1:0]              rom_addr_s;
    logic [COEF_WIDTH-1:0]        rom_data_s;
    logic signed [ACC_WIDTH-1:0]  addend_s;
    logic signed [ACC_WIDTH-1:0]  acc_next_s;
    logic signed [ACC_WIDTH-1:0]  result_s;
`ifdef DISTB_FIR_SCALE_EN
    logic signed [ACC_WIDTH-1:0]  rounded_s;
`endif

    distb_table u_table (
        .addr (rom_addr_s),
        .data (rom_data_s)
    );

    // Gather the current bit of every tap into the ROM address.
    always_comb begin
        rom_addr_s = {tap3_r[bit_cnt_r], tap2_r[bit_cnt_r], tap1_r[bit_cnt_r], tap0_r[bit_cnt_r]};
    end

    // Weighted partial sum: added for value bits, subtracted for the sign bit.
    always_comb begin
        addend_s   = coef_extend(rom_data_s) <<< bit_cnt_r;
        acc_next_s = acc_r;
        result_s   = acc_r;
        if (bit_cnt_r == LAST_BIT) begin
            acc_next_s = acc_r - addend_s;
        end else begin
            acc_next_s = acc_r + addend_s;
        end
`ifdef DISTB_FIR_SCALE_EN
        rounded_s = acc_next_s + ROUND_BIAS;
        result_s  = rounded_s >>> SCALE_SHIFT;
`else
        result_s  = acc_next_s;
`endif
    end

    // Sequencer FSM with delay line, accumulator and registered handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            tap0_r      <= '0;
            tap1_r      <= '0;
            tap2_r      <= '0;
            tap3_r      <= '0;
            acc_r       <= '0;
            bit_cnt_r   <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        tap3_r     <= tap2_r;
                        tap2_r     <= tap1_r;
                        tap1_r     <= tap0_r;
                        tap0_r     <= in_data;
                        acc_r      <= '0;
                        bit_cnt_r  <= '0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= CALC;
                    end else begin
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                CALC: begin
                    acc_r <= acc_next_s;
                    if (bit_cnt_r == LAST_BIT) begin
                        out_data_r  <= result_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    // Only the output handshake completes here; a waiting
                    // input sample is taken on the following cycle.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_distb_fir_ctrl.sv
// Directed self-checking bench for distb_fir_ctrl. Expected values are raw
// FIR sums of the coefficients 41/132/341/510; when DISTB_FIR_SCALE_EN is
// defined they are passed through the rounding divide by 1024.
module tb_distb_fir_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [19:0] out_data;
    logic        out_ready;
    logic        busy;

    int checks;
    int failures;

    distb_fir_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [19:0] scaled(input logic signed [19:0] raw);
`ifdef DISTB_FIR_SCALE_EN
        logic signed [19:0] t;
        t = raw + 20'sd512;
        return t >>> 10;
`else
        return raw;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Offer one sample in IDLE and wait (bounded) for its result.
    task automatic run_sample(input logic [7:0] d, input bit consume,
                              output logic [19:0] res, output int lat,
                              output bit acc_ok, output bit got);
        acc_ok = (in_ready === 1'b1);
        in_valid = 1'b1;
        in_data = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        res = '0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (out_valid === 1'b1) begin
                got = 1'b1;
                res = out_data;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        if (consume && got) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 20'd0) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b out_data=%0d required 1 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
    endtask

    task automatic test_impulse();
        logic [7:0]  stim [5];
        logic [19:0] expv [5];
        logic [19:0] res;
        int lat;
        bit ok, got;
        stim = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        expv = '{20'd41, 20'd132, 20'd341, 20'd510, 20'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_sample(stim[i], 1'b1, res, lat, ok, got);
            checks++;
            if (!ok || !got || res !== scaled(expv[i])) begin
                failures++;
                $display("FAIL impulse[%0d]: accepted=%0d got=%0d out=%0d required %0d",
                         i, ok, got, $signed(res), scaled(expv[i]));
            end
            if (i == 0) begin
                checks++;
                if (lat != 8) begin
                    failures++;
                    $display("FAIL latency: out_valid after %0d cycles, required 8", lat);
                end
            end
        end
    endtask

    task automatic test_sign_bit();
        logic [19:0] res;
        logic [19:0] raw;
        int lat;
        bit ok, got;
        raw = -20'sd5248;
        do_reset();
        run_sample(8'h80, 1'b1, res, lat, ok, got);
        checks++;
        if (!got || res !== scaled(raw)) begin
            failures++;
            $display("FAIL sign_bit: got=%0d out=%0d required %0d", got, $signed(res), scaled(raw));
        end
    endtask

    task automatic test_dc();
        logic [19:0] expv [5];
        logic [19:0] res;
        int lat;
        bit ok, got;
        expv = '{20'd5207, 20'd21971, 20'd65278, 20'd130048, 20'd130048};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_sample(8'd127, 1'b1, res, lat, ok, got);
            checks++;
            if (!got || res !== scaled(expv[i])) begin
                failures++;
                $display("FAIL dc[%0d]: got=%0d out=%0d required %0d",
                         i, got, $signed(res), scaled(expv[i]));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [19:0] res;
        int lat;
        bit ok, got;
        do_reset();
        run_sample(8'd1, 1'b0, res, lat, ok, got);
        checks++;
        if (!got || res !== scaled(20'd41)) begin
            failures++;
            $display("FAIL bp_first: got=%0d out=%0d required %0d", got, $signed(res), scaled(20'd41));
        end
        in_valid = 1'b1;
        in_data = 8'd5;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, busy} !== 3'b101 || out_data !== scaled(20'd41)) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid/ready/busy=%b%b%b out=%0d required 101 %0d",
                         c, out_valid, in_ready, busy, $signed(out_data), scaled(20'd41));
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        // Taps must hold only the accepted samples: 5*41 + 1*132.
        run_sample(8'd5, 1'b1, res, lat, ok, got);
        checks++;
        if (!ok || !got || res !== scaled(20'd337) || lat != 8) begin
            failures++;
            $display("FAIL bp_next: accepted=%0d got=%0d lat=%0d out=%0d required 1 1 8 %0d",
                     ok, got, lat, $signed(res), scaled(20'd337));
        end
    endtask

    task automatic test_back_to_back();
        int          acc_t [$];
        logic [19:0] outs [$];
        logic [19:0] expv [4];
        expv = '{20'd82, 20'd346, 20'd1028, 20'd2048};
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'd2;
        for (int c = 0; c < 40; c++) begin
            if (in_ready === 1'b1) acc_t.push_back(c);
            if (out_valid === 1'b1) outs.push_back(out_data);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (acc_t.size() != 4 || outs.size() != 4) begin
            failures++;
            $display("FAIL b2b_count: accepts=%0d outputs=%0d required 4 4", acc_t.size(), outs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (acc_t[i+1] - acc_t[i] != 10) begin
                    failures++;
                    $display("FAIL b2b_spacing[%0d]: %0d cycles, required 10", i, acc_t[i+1] - acc_t[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (outs[i] !== scaled(expv[i])) begin
                    failures++;
                    $display("FAIL b2b_out[%0d]: %0d required %0d", i, $signed(outs[i]), scaled(expv[i]));
                end
            end
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [19:0] res;
        int lat;
        bit ok, got, seen;
        do_reset();
        in_valid = 1'b1;
        in_data = 8'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid: busy=%b out_valid=%b in_ready=%b required 0 0 1", busy, out_valid, in_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rst_no_pulse: out_valid observed=1 required 0");
        end
        run_sample(8'd1, 1'b1, res, lat, ok, got);
        checks++;
        if (!ok || !got || res !== scaled(20'd41)) begin
            failures++;
            $display("FAIL rst_after: accepted=%0d got=%0d out=%0d required %0d",
                     ok, got, $signed(res), scaled(20'd41));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'd0;
        out_ready = 1'b0;
        test_reset();
        test_impulse();
        test_sign_bit();
        test_dc();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
